// File: rtl/alu16_pkg.sv
// Shared types and step counts for the nibble/bit-serial 16-bit ALU sequencer.
package alu16_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOTA = 4'd5,
    OP_MUL  = 4'd6,
    OP_DIV  = 4'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    NIB  = 3'd1,
    MUL  = 3'd2,
    DIV  = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam int          NIB_STEPS   = 4;
  localparam int          MD_STEPS    = 16;
  localparam logic [31:0] DIV0_RESULT = 32'h0000_FFFF;

endpackage

// File: rtl/alu16_seq_ctrl_alu4_slice.sv
// Combinational 4-bit ALU slice: add/sub with carry chain plus bitwise ops.
module alu4_slice
  import alu16_pkg::*;
#(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  input  logic [3:0]         op,
  output logic [SLICE_W-1:0] y,
  output logic               cout
);

  always_comb begin
    y    = '0;
    cout = 1'b0;
    case (op)
      OP_ADD:  {cout, y} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
      // Subtract as A + ~B + cin; the controller seeds cin=1 on nibble 0.
      OP_SUB:  {cout, y} = {1'b0, a} + {1'b0, ~b} + {{SLICE_W{1'b0}}, cin};
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOTA: y = ~a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu16_seq_ctrl.sv
// Multi-cycle 16-bit ALU sequencer around a single 4-bit slice.
// Optional ALU16_SEQ_ABORT_EN adds an abort input for in-flight operations.
module alu16_seq_ctrl
  import alu16_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int SLICE_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [3:0]        req_op,
`ifdef ALU16_SEQ_ABORT_EN
  input  logic              abort,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_result,
  output logic              rsp_carry,
  output logic [15:0]       rsp_remainder,
  output logic              rsp_err
);

  if ((DATA_W % SLICE_W) != 0 || DATA_W != 16) begin : g_bad_width
    $error("alu16_seq_ctrl: DATA_W must be 16 and a multiple of SLICE_W");
  end

  state_e      state_reg, state_next;
  logic        ready_en_reg;
  logic [3:0]  op_reg, op_next;
  logic [15:0] a_reg, a_next;
  logic [15:0] b_reg, b_next;
  logic [31:0] acc_reg, acc_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic        carry_reg, carry_next;
  logic        illegal_reg, illegal_next;
  logic        div0_reg, div0_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic [31:0] rsp_result_reg, rsp_result_next;
  logic        rsp_carry_reg, rsp_carry_next;
  logic [15:0] rsp_rem_reg, rsp_rem_next;
  logic        rsp_err_reg, rsp_err_next;

  logic [SLICE_W-1:0] slice_y;
  logic               slice_cout;
  logic [16:0]        mul_sum;
  logic [16:0]        div_rem_sh;
  logic [16:0]        div_diff;
  logic               abort_hit;

`ifdef ALU16_SEQ_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  alu4_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a    (a_reg[SLICE_W-1:0]),
    .b    (b_reg[SLICE_W-1:0]),
    .cin  (carry_reg),
    .op   (op_reg),
    .y    (slice_y),
    .cout (slice_cout)
  );

  // Multiply: product high half accumulates A, low half holds the shifting multiplier.
  assign mul_sum    = {1'b0, acc_reg[31:16]} + (acc_reg[0] ? {1'b0, a_reg} : 17'd0);
  // Divide: acc = {partial remainder, dividend/quotient bits}.
  assign div_rem_sh = acc_reg[31:15];
  assign div_diff   = div_rem_sh - {1'b0, b_reg};

  assign req_ready     = ready_en_reg && (state_reg == IDLE);
  assign rsp_valid     = rsp_valid_reg;
  assign rsp_result    = rsp_result_reg;
  assign rsp_carry     = rsp_carry_reg;
  assign rsp_remainder = rsp_rem_reg;
  assign rsp_err       = rsp_err_reg;

  always_comb begin
    state_next      = state_reg;
    op_next         = op_reg;
    a_next          = a_reg;
    b_next          = b_reg;
    acc_next        = acc_reg;
    cnt_next        = cnt_reg;
    carry_next      = carry_reg;
    illegal_next    = illegal_reg;
    div0_next       = div0_reg;
    rsp_valid_next  = rsp_valid_reg;
    rsp_result_next = rsp_result_reg;
    rsp_carry_next  = rsp_carry_reg;
    rsp_rem_next    = rsp_rem_reg;
    rsp_err_next    = rsp_err_reg;

    case (state_reg)
      IDLE: begin
        if (req_valid && req_ready) begin
          op_next      = req_op;
          a_next       = req_a;
          b_next       = req_b;
          cnt_next     = '0;
          carry_next   = (req_op == OP_SUB);
          illegal_next = req_op[3];
          div0_next    = (req_op == OP_DIV) && (req_b == 16'd0);
          acc_next     = '0;
          if (req_op[3] || ((req_op == OP_DIV) && (req_b == 16'd0))) begin
            state_next = DONE;
          end else if (req_op == OP_MUL) begin
            acc_next   = {16'd0, req_b};
            state_next = MUL;
          end else if (req_op == OP_DIV) begin
            acc_next   = {16'd0, req_a};
            state_next = DIV;
          end else begin
            state_next = NIB;
          end
        end
      end
      NIB: begin
        acc_next   = {16'd0, slice_y, acc_reg[15:SLICE_W]};
        a_next     = a_reg >> SLICE_W;
        b_next     = b_reg >> SLICE_W;
        carry_next = slice_cout;
        cnt_next   = cnt_reg + 5'd1;
        if (cnt_reg == 5'(NIB_STEPS - 1)) state_next = DONE;
        if (abort_hit) state_next = IDLE;
      end
      MUL: begin
        acc_next = {mul_sum, acc_reg[15:1]};
        cnt_next = cnt_reg + 5'd1;
        if (cnt_reg == 5'(MD_STEPS - 1)) state_next = DONE;
        if (abort_hit) state_next = IDLE;
      end
      DIV: begin
        if (!div_diff[16]) acc_next = {div_diff[15:0], acc_reg[14:0], 1'b1};
        else               acc_next = {div_rem_sh[15:0], acc_reg[14:0], 1'b0};
        cnt_next = cnt_reg + 5'd1;
        if (cnt_reg == 5'(MD_STEPS - 1)) state_next = DONE;
        if (abort_hit) state_next = IDLE;
      end
      DONE: begin
        // First DONE cycle formats the response; later cycles wait for the consumer.
        if (!rsp_valid_reg) begin
          rsp_valid_next  = 1'b1;
          rsp_result_next = '0;
          rsp_carry_next  = 1'b0;
          rsp_rem_next    = '0;
          rsp_err_next    = 1'b0;
          if (illegal_reg) begin
            rsp_err_next = 1'b1;
          end else if (div0_reg) begin
            rsp_result_next = DIV0_RESULT;
            rsp_rem_next    = a_reg;
            rsp_err_next    = 1'b1;
          end else if (op_reg == OP_MUL) begin
            rsp_result_next = acc_reg;
            rsp_carry_next  = |acc_reg[31:16];
          end else if (op_reg == OP_DIV) begin
            rsp_result_next = {16'd0, acc_reg[15:0]};
            rsp_rem_next    = acc_reg[31:16];
          end else begin
            rsp_result_next = {16'd0, acc_reg[15:0]};
            rsp_carry_next  = ((op_reg == OP_ADD) || (op_reg == OP_SUB)) ? carry_reg : 1'b0;
          end
        end else if (rsp_ready) begin
          rsp_valid_next  = 1'b0;
          rsp_result_next = '0;
          rsp_carry_next  = 1'b0;
          rsp_rem_next    = '0;
          rsp_err_next    = 1'b0;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      ready_en_reg   <= 1'b0;
      op_reg         <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      acc_reg        <= '0;
      cnt_reg        <= '0;
      carry_reg      <= 1'b0;
      illegal_reg    <= 1'b0;
      div0_reg       <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_result_reg <= '0;
      rsp_carry_reg  <= 1'b0;
      rsp_rem_reg    <= '0;
      rsp_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ready_en_reg   <= 1'b1;
      op_reg         <= op_next;
      a_reg          <= a_next;
      b_reg          <= b_next;
      acc_reg        <= acc_next;
      cnt_reg        <= cnt_next;
      carry_reg      <= carry_next;
      illegal_reg    <= illegal_next;
      div0_reg       <= div0_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_result_reg <= rsp_result_next;
      rsp_carry_reg  <= rsp_carry_next;
      rsp_rem_reg    <= rsp_rem_next;
      rsp_err_reg    <= rsp_err_next;
    end
  end

endmodule

// File: tb/tb_alu16_seq_ctrl.sv
// Scoreboard bench for alu16_seq_ctrl: reference arithmetic, latency, backpressure, reset abort.
module tb_alu16_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [3:0]  req_op = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_carry;
  logic [15:0] rsp_remainder;
  logic        rsp_err;
`ifdef ALU16_SEQ_ABORT_EN
  logic        abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic [15:0] rem;
    logic        e;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  always #5 clk = ~clk;

  alu16_seq_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_op        (req_op),
`ifdef ALU16_SEQ_ABORT_EN
    .abort         (abort),
`endif
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_carry     (rsp_carry),
    .rsp_remainder (rsp_remainder),
    .rsp_err       (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    exp_t x;
    logic [16:0] s;
    x.res = '0; x.c = 1'b0; x.rem = '0; x.e = 1'b0; x.lat = 5;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; x.res = {16'd0, s[15:0]}; x.c = s[16]; end
      4'd1: begin x.res = {16'd0, a - b}; x.c = (a >= b); end
      4'd2: x.res = {16'd0, a & b};
      4'd3: x.res = {16'd0, a | b};
      4'd4: x.res = {16'd0, a ^ b};
      4'd5: x.res = {16'd0, ~a};
      4'd6: begin x.res = {16'd0, a} * {16'd0, b}; x.c = |x.res[31:16]; x.lat = 17; end
      4'd7: begin
        if (b == 16'd0) begin x.res = 32'h0000_FFFF; x.rem = a; x.e = 1'b1; x.lat = 1; end
        else begin x.res = {16'd0, a / b}; x.rem = a % b; x.lat = 17; end
      end
      default: begin x.e = 1'b1; x.lat = 1; end
    endcase
    return x;
  endfunction

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    int n;
    @(negedge clk);
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("req_ready_drop", 32'(req_ready), 32'd0);
    sb.push_back(model(a, b, op));
  endtask

  task automatic wait_rsp();
    int lat;
    lat = 0;
    do begin
      @(posedge clk); lat++; #1;
    end while (!rsp_valid && lat < 40);
    cur = sb.pop_front();
    chk("latency", 32'(lat), 32'(cur.lat));
    chk("result", rsp_result, cur.res);
    chk("carry", 32'(rsp_carry), 32'(cur.c));
    chk("remainder", 32'(rsp_remainder), 32'(cur.rem));
    chk("err", 32'(rsp_err), 32'(cur.e));
    $display("op done: result=%h carry=%0d rem=%h err=%0d lat=%0d",
             rsp_result, rsp_carry, rsp_remainder, rsp_err, lat);
  endtask

  task automatic release_rsp(input int hold);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_result", rsp_result, cur.res);
      chk("hold_rem", 32'(rsp_remainder), 32'(cur.rem));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("clr_valid", 32'(rsp_valid), 32'd0);
    chk("clr_result", rsp_result, 32'd0);
    chk("clr_misc", {29'd0, rsp_carry, rsp_err, |rsp_remainder}, 32'd0);
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    issue(a, b, op);
    wait_rsp();
    release_rsp(0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp", {rsp_valid, rsp_carry, rsp_err, 13'd0, rsp_remainder}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_req_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("rel_req_ready_high", 32'(req_ready), 32'd1);

    run(16'hFFFF, 16'h0001, 4'd0);
    run(16'h0003, 16'h0005, 4'd1);
    run(16'h0005, 16'h0003, 4'd1);
    run(16'hF0F0, 16'h3C3C, 4'd2);
    run(16'hF0F0, 16'h3C3C, 4'd3);
    run(16'hF0F0, 16'h3C3C, 4'd4);
    run(16'h1234, 16'h0000, 4'd5);
    run(16'h1234, 16'h5678, 4'd6);
    run(16'hFFFF, 16'hFFFF, 4'd6);
    run(16'd100,  16'd7,    4'd7);
    run(16'hFFFF, 16'h0001, 4'd7);
    run(16'h00AB, 16'h0000, 4'd7);
    run(16'h1111, 16'h2222, 4'hC);
    run(16'h1111, 16'h2222, 4'hF);

    // Backpressure, with the next request held valid during the response hold
    issue(16'h0102, 16'h0304, 4'd0);
    wait_rsp();
    @(negedge clk);
    req_a = 16'h0010; req_b = 16'h0020; req_op = 4'd0; req_valid = 1'b1;
    release_rsp(3);
    chk("req_ready_after_hs", 32'(req_ready), 32'd1);
    issue(16'h0010, 16'h0020, 4'd0);
    wait_rsp();
    release_rsp(1);

    // Random mix
    for (int i = 0; i < 24; i++) begin
      run(16'($urandom), 16'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : $urandom),
          4'($urandom_range(0, 9)));
    end

    // Reset during MUL step 8
    issue(16'h1234, 16'h5678, 4'd6);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_front());
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_rsp_result", rsp_result, 32'd0);
    chk("abort_rsp_misc", {rsp_carry, rsp_err, 14'd0, rsp_remainder}, 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (25) begin
        @(negedge clk);
        if (rsp_valid) seen++;
      end
      chk("no_rsp_after_reset", 32'(seen), 32'd0);
    end
    run(16'd1, 16'd1, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu16_seq_ctrl.md
Name: alu16_seq_ctrl

Overview:
Multi-cycle sequencer wrapping a single 4-bit ALU slice to execute 16-bit operations nibble-serially (add/sub/logic) or bit-serially (multiply, restoring divide). Accepts one request at a time over a valid/ready handshake and returns a 32-bit result, carry, remainder and status over a second valid/ready handshake. Replaces four parallel 4-bit slices where area matters more than latency; opcode set and result format match the 16-bit ALU datapath.

Parameters:
DATA_W, 16, operand width; fixed at 16 in this revision, present for lint/assertions.
SLICE_W, 4, slice width; DATA_W must be a multiple of SLICE_W (elaboration-time check).

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  controller can accept; high only in IDLE.
req_a  input  16  operand A.
req_b  input  16  operand B.
req_op  input  4  opcode (see Behaviour).
rsp_valid  output  1  response present; held until rsp_ready.
rsp_ready  input  1  consumer accepts response.
rsp_result  output  32  result; zero-extended for 16-bit ops.
rsp_carry  output  1  carry/flag (see Behaviour).
rsp_remainder  output  16  DIV remainder, else 0.
rsp_err  output  1  illegal opcode or divide-by-zero.

Behaviour:
- Reset: req_ready=0 while rst_n low, 1 from first edge after release; all rsp_* outputs 0; state IDLE. Reset mid-operation aborts immediately; operation is lost, no response is issued.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOTA, 6 MUL, 7 DIV; 8-15 illegal.
- Accept on clk edge with req_valid&&req_ready; operands and opcode latched; req_ready drops the same edge.
- States: IDLE -> NIB (ops 0-5) | MUL | DIV | DONE (illegal, or DIV with B=0); NIB/MUL/DIV -> DONE on final step; DONE -> IDLE on rsp_valid&&rsp_ready.
- NIB: 4 cycles, nibble 0 first; slice carry registered between nibbles; SUB = A + ~B + 1 (carry-in 1 on nibble 0).
- MUL: 16 cycles of shift-add, LSB of B first; 32-bit unsigned product.
- DIV: 16 cycles of restoring division, unsigned; quotient in rsp_result[15:0], remainder in rsp_remainder.
- Latency (accept edge to rsp_valid high): NIB 5 edges, MUL/DIV 17 edges, illegal/div-by-zero 1 edge.
- rsp_carry: ADD = carry out of bit 15; SUB = no-borrow (1 when A>=B); MUL = |product[31:16]; else 0.
- Error: illegal -> result 0, carry 0, err 1. DIV with B=0 -> result 32'h0000_FFFF, remainder=A, err 1.
- rsp_* registered, stable while rsp_valid && !rsp_ready; all rsp_* cleared to 0 on handshake. No new accept in the handshake cycle; req_ready returns high on the next edge.

Optional Feature:
ALU16_SEQ_ABORT_EN: adds input port abort (1 bit). When high in NIB/MUL/DIV, returns to IDLE on the next edge with no response issued; ignored in IDLE and DONE. When the macro is undefined, the port is absent and operations always run to completion.

Decomposition:
- Package alu16_pkg: opcode enum (OP_ADD..OP_DIV), state enum (IDLE, NIB, MUL, DIV, DONE), latency constants NIB_STEPS=4, MD_STEPS=16, DIV0_RESULT=32'h0000_FFFF.
- One sub-module alu4_slice: combinational 4-bit add/sub/logic with carry-in/carry-out. The controller instantiates it once; MUL/DIV adders stay in the controller.

Test Plan:
- ADD A=16'hFFFF, B=16'h0001 -> rsp_result 32'h0000_0000, carry 1, err 0; rsp_valid 5 edges after accept.
- SUB A=16'h0003, B=16'h0005 -> result 32'h0000_FFFE, carry 0; SUB A=5, B=3 -> result 32'h0000_0002, carry 1.
- MUL A=16'h1234, B=16'h5678 -> result 32'h0626_0060, carry 1; rsp_valid 17 edges after accept.
- DIV A=100, B=7 -> result 14, remainder 2, err 0. DIV B=0, A=16'h00AB -> result 32'h0000_FFFF, remainder 16'h00AB, err 1, 1-edge latency. op=4'hC -> err 1, result 0.
- Backpressure: hold rsp_ready low 3 cycles after rsp_valid -> outputs stable, req_ready 0; req_valid held high is not accepted until the edge after the handshake.
- Assert rst_n low during MUL step 8 -> all rsp_* 0 immediately; no rsp_valid after release; next ADD 1+1 returns 2.
